// File: rtl/us_pkg.sv
// us_pkg: receiver FSM state type and default timing parameters for us_burst_rx.
package us_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_QUALIFY,
        ST_LOCKED,
        ST_HOLDOFF
    } us_state_t;
    localparam int MIN_EDGES_DEF = 4;
    localparam int GAP_MAX_DEF   = 2500;
    localparam int HOLDOFF_DEF   = 7000;
endpackage

// File: rtl/us_input_conditioner.sv
// us_input_conditioner: piezo synchronizer, optional majority glitch filter, rising-edge detect.
// Optional filter: US_RX_GLITCH_FILTER_EN.
module us_input_conditioner (
    input  logic clock,
    input  logic reset,
    input  logic piezo_interface_in,
    output logic rise
);
    logic [1:0] sync;
    logic       s;
    logic       s_prev;
    always_ff @(posedge clock or posedge reset)
        if (reset) sync <= '0;
        else sync <= {sync[0], piezo_interface_in};
`ifdef US_RX_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       maj;
    // Majority over three consecutive samples drops any single-cycle pulse.
    assign maj = (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            hist <= '0;
            s    <= 1'b0;
        end else begin
            hist <= {hist[0], sync[1]};
            s    <= maj;
        end
`else
    assign s = sync[1];
`endif
    always_ff @(posedge clock or posedge reset)
        if (reset) s_prev <= 1'b0;
        else s_prev <= s;
    assign rise = s & ~s_prev;
endmodule

// File: rtl/us_burst_rx.sv
// us_burst_rx: ultrasonic burst receiver - qualifies edge bursts, timestamps them, enforces holdoff.
// Optional input glitch filter: US_RX_GLITCH_FILTER_EN.
module us_burst_rx
    import us_pkg::*;
#(
    parameter int MIN_EDGES = MIN_EDGES_DEF,
    parameter int GAP_MAX   = GAP_MAX_DEF,
    parameter int HOLDOFF   = HOLDOFF_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        piezo_interface_in,
    output logic        detect,
    output logic        done,
    output logic [31:0] timestamp,
    output logic [15:0] burst_len,
    output logic        busy,
    output logic        wrapped
);
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam int HW = $clog2(HOLDOFF + 1);
    us_state_t     state;
    logic          rise;
    logic [31:0]   time_cnt;
    logic [31:0]   cand_ts;
    logic [15:0]   edge_cnt;
    logic [15:0]   edge_inc;
    logic [GW-1:0] gap_cnt;
    logic [HW-1:0] hold_cnt;
    logic          idle_next;
    logic          gap_out;

    us_input_conditioner u_cond (
        .clock              (clock),
        .reset              (reset),
        .piezo_interface_in (piezo_interface_in),
        .rise               (rise)
    );

    // time_cnt must already read 0 in the first IDLE cycle after enable drops.
    assign idle_next = !enable || state == ST_IDLE;
    assign gap_out   = gap_cnt == GW'(GAP_MAX);
    assign edge_inc  = (edge_cnt == 16'hFFFF) ? edge_cnt : edge_cnt + 16'd1;
    assign busy      = state == ST_QUALIFY || state == ST_LOCKED || state == ST_HOLDOFF;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            time_cnt  <= '0;
            wrapped   <= 1'b0;
            cand_ts   <= '0;
            edge_cnt  <= '0;
            gap_cnt   <= '0;
            hold_cnt  <= '0;
            detect    <= 1'b0;
            done      <= 1'b0;
            timestamp <= '0;
            burst_len <= '0;
        end else begin
            detect   <= 1'b0;
            done     <= 1'b0;
            time_cnt <= idle_next ? '0 : time_cnt + 32'd1;
            wrapped  <= !idle_next && (wrapped || time_cnt == '1);
            if (!enable) state <= ST_IDLE;
            else case (state)
                ST_IDLE: state <= ST_ARMED;
                ST_ARMED:
                    if (rise) begin
                        cand_ts  <= time_cnt;
                        edge_cnt <= 16'd1;
                        gap_cnt  <= '0;
                        state    <= ST_QUALIFY;
                    end
                ST_QUALIFY:
                    if (rise) begin
                        edge_cnt <= edge_inc;
                        gap_cnt  <= '0;
                        if (edge_inc >= 16'(MIN_EDGES)) begin
                            state     <= ST_LOCKED;
                            detect    <= 1'b1;
                            timestamp <= cand_ts;
                        end
                    end else if (gap_out) state <= ST_ARMED;
                    else gap_cnt <= gap_cnt + GW'(1);
                ST_LOCKED:
                    if (rise) begin
                        edge_cnt <= edge_inc;
                        gap_cnt  <= '0;
                    end else if (gap_out) begin
                        state     <= ST_HOLDOFF;
                        burst_len <= edge_cnt;
                        done      <= 1'b1;
                        hold_cnt  <= '0;
                    end else gap_cnt <= gap_cnt + GW'(1);
                ST_HOLDOFF:
                    if (hold_cnt == HW'(HOLDOFF - 1)) state <= ST_ARMED;
                    else hold_cnt <= hold_cnt + HW'(1);
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
